frame_write_ctrl: RTL and testbench

FRAME_WRITE_CTRL -- requirements
Module: frame_write_ctrl

---
 rtl/frame_write_ctrl.sv | 160 ++++++++++++++++
 tb/tb_frame_write_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_write_ctrl.sv
// Frame write controller: moves pixel words from the input FIFO into a
// triple-buffered frame store using fixed-size memory write bursts.
module frame_write_ctrl #(
    parameter int BURST_LEN   = 64,
    parameter int FRAME_WORDS = 307200,
    parameter int ADDR_W      = 25
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              write_req,
    output logic              write_req_ack,
    input  logic [9:0]        fifo_rdusedw,
    output logic              fifo_rd_en,
    output logic              wr_burst_req,
    output logic [9:0]        wr_burst_len,
    output logic [ADDR_W-1:0] wr_burst_addr,
    input  logic              wr_burst_data_req,
    input  logic              wr_burst_finish,
    output logic [1:0]        write_addr_index,
    output logic [1:0]        read_addr_index,
    output logic              frame_done,
    output logic              busy
);
    // state     | meaning
    // IDLE      | waiting for write_req
    // ACK       | acknowledge request, load frame counters
    // WAIT_DATA | wait until the FIFO holds the next burst
    // BURST     | memory burst in flight
    // FRAME_END | publish finished buffer, advance write buffer
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ACK       = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_BURST     = 3'd3,
        S_FRAME_END = 3'd4
    } state_t;

    localparam int                FRAME_CW      = $clog2(FRAME_WORDS + 1);
    localparam int                CNT_W         = (FRAME_CW > 20) ? FRAME_CW : 20;
    localparam logic [CNT_W-1:0]  BURST_LEN_C   = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  FRAME_WORDS_C = CNT_W'(FRAME_WORDS);
    localparam logic [9:0]        BURST_LEN_W   = 10'(BURST_LEN);
    localparam logic [ADDR_W-1:0] BASE_1        = ADDR_W'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] BASE_2        = ADDR_W'(2 * FRAME_WORDS);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   offset_q, offset_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [9:0]         beat_q, beat_d;
    logic [9:0]         len_q, len_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [1:0]         wr_idx_q, wr_idx_d;
    logic [1:0]         rd_idx_q, rd_idx_d;

    logic [9:0]         len_next;
    logic [ADDR_W-1:0]  base_addr;
    logic [CNT_W-1:0]   remaining_after;

    // Last burst of a frame shrinks to whatever is left.
    always_comb begin
        if (remaining_q < BURST_LEN_C) begin
            len_next = remaining_q[9:0];
        end else begin
            len_next = BURST_LEN_W;
        end
    end

    always_comb begin
        case (wr_idx_q)
            2'd1:    base_addr = BASE_1;
            2'd2:    base_addr = BASE_2;
            default: base_addr = '0;
        endcase
    end

    assign remaining_after = remaining_q - CNT_W'(len_q);

    assign write_req_ack    = (state_q == S_ACK);
    assign wr_burst_req     = (state_q == S_BURST);
    assign frame_done       = (state_q == S_FRAME_END);
    assign busy             = (state_q != S_IDLE);
    assign fifo_rd_en       = (state_q == S_BURST) && wr_burst_data_req && (beat_q < len_q);
    assign wr_burst_len     = len_q;
    assign wr_burst_addr    = addr_q;
    assign write_addr_index = wr_idx_q;
    assign read_addr_index  = rd_idx_q;

    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        remaining_d = remaining_q;
        beat_d      = beat_q;
        len_d       = len_q;
        addr_d      = addr_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        case (state_q)
            S_IDLE: begin
                if (write_req) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                offset_d    = '0;
                remaining_d = FRAME_WORDS_C;
                state_d     = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                if (fifo_rdusedw >= len_next) begin
                    len_d   = len_next;
                    addr_d  = base_addr + ADDR_W'(offset_q);
                    beat_d  = '0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                // Pops stop at the burst length even if memory keeps pulling.
                if (fifo_rd_en) begin
                    beat_d = beat_q + 10'd1;
                end
                if (wr_burst_finish) begin
                    offset_d    = offset_q + CNT_W'(len_q);
                    remaining_d = remaining_after;
                    state_d     = (remaining_after == '0) ? S_FRAME_END : S_WAIT_DATA;
                end
            end
            S_FRAME_END: begin
                rd_idx_d = wr_idx_q;
                wr_idx_d = (wr_idx_q == 2'd2) ? 2'd0 : wr_idx_q + 2'd1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            offset_q    <= '0;
            remaining_q <= '0;
            beat_q      <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            wr_idx_q    <= 2'd0;
            rd_idx_q    <= 2'd2;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            remaining_q <= remaining_d;
            beat_q      <= beat_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
        end
    end

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Scoreboard bench for frame_write_ctrl with a 200-word frame and 64-word bursts.
module tb_frame_write_ctrl;
    localparam int BURST_LEN   = 64;
    localparam int FRAME_WORDS = 200;
    localparam int ADDR_W      = 25;

    logic              pclk = 1'b0;
    logic              rst;
    logic              write_req;
    logic              write_req_ack;
    logic [9:0]        fifo_rdusedw;
    logic              fifo_rd_en;
    logic              wr_burst_req;
    logic [9:0]        wr_burst_len;
    logic [ADDR_W-1:0] wr_burst_addr;
    logic              wr_burst_data_req;
    logic              wr_burst_finish;
    logic [1:0]        write_addr_index;
    logic [1:0]        read_addr_index;
    logic              frame_done;
    logic              busy;

    frame_write_ctrl #(
        .BURST_LEN  (BURST_LEN),
        .FRAME_WORDS(FRAME_WORDS),
        .ADDR_W     (ADDR_W)
    ) dut (
        .pclk             (pclk),
        .rst              (rst),
        .write_req        (write_req),
        .write_req_ack    (write_req_ack),
        .fifo_rdusedw     (fifo_rdusedw),
        .fifo_rd_en       (fifo_rd_en),
        .wr_burst_req     (wr_burst_req),
        .wr_burst_len     (wr_burst_len),
        .wr_burst_addr    (wr_burst_addr),
        .wr_burst_data_req(wr_burst_data_req),
        .wr_burst_finish  (wr_burst_finish),
        .write_addr_index (write_addr_index),
        .read_addr_index  (read_addr_index),
        .frame_done       (frame_done),
        .busy             (busy)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int len;
        int addr;
    } burst_t;

    typedef struct {
        int wr;
        int rd;
    } frame_t;

    burst_t exp_bursts[$];
    frame_t exp_frames[$];
    int     n_checks       = 0;
    int     n_errors       = 0;
    int     pull_count     = 0;
    int     bursts_started = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Hand-computed burst plan for 200 words in 64-word bursts.
    task automatic push_frame(input int w, input int nbursts, input bit full);
        int lens[4];
        int offs[4];
        int bases[3];
        burst_t b;
        frame_t f;
        lens  = '{64, 64, 64, 8};
        offs  = '{0, 64, 128, 192};
        bases = '{0, 200, 400};
        for (int i = 0; i < nbursts; i++) begin
            b.len  = lens[i];
            b.addr = bases[w] + offs[i];
            exp_bursts.push_back(b);
        end
        if (full) begin
            f.wr = (w == 2) ? 0 : w + 1;
            f.rd = w;
            exp_frames.push_back(f);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_write_req_ack", write_req_ack, 0);
        check("rst_fifo_rd_en", fifo_rd_en, 0);
        check("rst_wr_burst_req", wr_burst_req, 0);
        check("rst_wr_burst_len", wr_burst_len, 0);
        check("rst_wr_burst_addr", wr_burst_addr, 0);
        check("rst_write_addr_index", write_addr_index, 0);
        check("rst_read_addr_index", read_addr_index, 2);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy", busy, 0);
    endtask

    task automatic request_frame();
        int got;
        got = 0;
        @(posedge pclk); #1;
        write_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            if (write_req_ack) begin
                got = 1;
                break;
            end
        end
        check("ack_seen", got, 1);
        check("busy_after_ack", busy, 1);
        @(posedge pclk); #1;
        write_req = 1'b0;
    endtask

    task automatic wait_frame_done();
        int got;
        got = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge pclk);
            if (frame_done) begin
                got = 1;
                break;
            end
        end
        check("frame_done_seen", got, 1);
    endtask

    // Memory model: pulls data for each burst, then pulses finish.
    initial begin : mem_model
        wr_burst_data_req = 1'b0;
        wr_burst_finish   = 1'b0;
        forever begin
            @(posedge pclk); #1;
            if (wr_burst_req === 1'b1) begin
                int pulls;
                bit aborted;
                pulls   = (pull_count == 0) ? int'(wr_burst_len) : pull_count;
                aborted = 1'b0;
                for (int i = 0; i < pulls; i++) begin
                    if (!wr_burst_req) begin
                        aborted = 1'b1;
                        break;
                    end
                    wr_burst_data_req = 1'b1;
                    @(posedge pclk); #1;
                end
                wr_burst_data_req = 1'b0;
                if (!aborted && wr_burst_req) begin
                    wr_burst_finish = 1'b1;
                    @(posedge pclk); #1;
                    wr_burst_finish = 1'b0;
                end
            end
        end
    end

    // Monitor: pops expected bursts and frames as the DUT presents them.
    initial begin : monitor
        bit     in_burst;
        bit     burst_rst;
        bit     frame_pending;
        burst_t cur;
        frame_t curf;
        int     pops;
        in_burst      = 1'b0;
        burst_rst     = 1'b0;
        frame_pending = 1'b0;
        pops          = 0;
        cur.len       = -1;
        cur.addr      = -1;
        curf.wr       = -1;
        curf.rd       = -1;
        forever begin
            @(negedge pclk);
            if (frame_pending) begin
                check("frame_done_one_cycle", frame_done, 0);
                check("write_addr_index_after_frame", write_addr_index, curf.wr);
                check("read_addr_index_after_frame", read_addr_index, curf.rd);
                frame_pending = 1'b0;
            end
            if (frame_done === 1'b1) begin
                if (exp_frames.size() == 0) begin
                    check("unexpected_frame_done", frame_done, 0);
                end else begin
                    curf          = exp_frames.pop_front();
                    frame_pending = 1'b1;
                end
            end
            if (wr_burst_req === 1'b1 && !in_burst) begin
                in_burst  = 1'b1;
                burst_rst = 1'b0;
                pops      = 0;
                bursts_started++;
                if (exp_bursts.size() == 0) begin
                    check("unexpected_burst", wr_burst_req, 0);
                    cur.len  = -1;
                    cur.addr = -1;
                end else begin
                    cur = exp_bursts.pop_front();
                end
            end
            if (in_burst && wr_burst_req === 1'b1) begin
                check("wr_burst_len", wr_burst_len, cur.len);
                check("wr_burst_addr", wr_burst_addr, cur.addr);
                if (fifo_rd_en) pops++;
                if (rst) burst_rst = 1'b1;
            end else if (in_burst) begin
                in_burst = 1'b0;
                if (!burst_rst && !rst) begin
                    check("fifo_pops_per_burst", pops, cur.len);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int reqs;
        int acks;
        int got;
        int k;
        int b0;
        rst          = 1'b1;
        write_req    = 1'b0;
        fifo_rdusedw = 10'd1023;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check_reset_outputs();
        @(posedge pclk); #1;
        rst = 1'b0;

        // Single frame, then back-to-back frames through the index wrap.
        push_frame(0, 4, 1'b1);
        request_frame();
        wait_frame_done();
        push_frame(1, 4, 1'b1);
        request_frame();
        wait_frame_done();
        push_frame(2, 4, 1'b1);
        request_frame();
        wait_frame_done();
        push_frame(0, 4, 1'b1);
        request_frame();
        wait_frame_done();

        // FIFO one word short of a burst holds off the request.
        fifo_rdusedw = 10'd63;
        push_frame(1, 4, 1'b1);
        request_frame();
        reqs = 0;
        repeat (10) begin
            @(negedge pclk);
            if (wr_burst_req) reqs++;
        end
        check("no_burst_below_len", reqs, 0);
        @(posedge pclk); #1;
        fifo_rdusedw = 10'd64;
        @(negedge pclk);
        check("burst_req_same_cycle", wr_burst_req, 0);
        @(negedge pclk);
        check("burst_req_after_fifo_ready", wr_burst_req, 1);

        // Request raised mid-frame waits for IDLE; memory over-pulls next frame.
        @(posedge pclk); #1;
        write_req  = 1'b1;
        pull_count = 70;
        push_frame(2, 4, 1'b1);
        acks = 0;
        got  = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge pclk);
            if (write_req_ack) acks++;
            if (frame_done) begin
                got = 1;
                break;
            end
        end
        check("frame_done_seen", got, 1);
        check("no_ack_during_frame", acks, 0);
        k   = 0;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            k++;
            if (write_req_ack) begin
                got = 1;
                break;
            end
        end
        check("pending_ack_seen", got, 1);
        check("ack_delay_after_frame_done", k, 2);
        @(posedge pclk); #1;
        write_req = 1'b0;
        wait_frame_done();
        pull_count   = 0;
        fifo_rdusedw = 10'd1023;

        push_frame(0, 4, 1'b1);
        request_frame();
        wait_frame_done();

        // Reset during the second burst of a buffer-1 frame.
        push_frame(1, 2, 1'b0);
        b0 = bursts_started;
        request_frame();
        for (int i = 0; i < 500; i++) begin
            @(negedge pclk);
            if (bursts_started == b0 + 2) break;
        end
        check("second_burst_started", bursts_started - b0, 2);
        repeat (5) @(posedge pclk);
        #1;
        rst = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        check_reset_outputs();
        @(posedge pclk); #1;
        rst = 1'b0;

        push_frame(0, 4, 1'b1);
        request_frame();
        wait_frame_done();

        repeat (5) @(negedge pclk);
        check("bursts_outstanding", exp_bursts.size(), 0);
        check("frames_outstanding", exp_frames.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
